// File: rtl/imem_pkg.sv
// Shared constants for the loadable instruction memory: FSM state encodings,
// fetch fault codes and the default fill word.
package imem_pkg;

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_LOAD = 2'd2;

    localparam logic [1:0] FAULT_OK       = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE    = 2'b10;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

endpackage

// File: rtl/imem_array.sv
// DEPTH x DATA_W instruction storage: one synchronous write port and one
// combinational read port. Contents are not reset; the owner fills them.
module imem_array #(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 32,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Synchronous write port
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_loadable.sv
// Loadable instruction memory: NOP fill after reset, run-time program load
// port, and a valid/ready fetch port with a registered response and fault code.
module imem_loadable
    import imem_pkg::*;
#(
    parameter int                DEPTH    = 64,
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT),
    localparam int               AW       = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_en_i,
    input  logic [AW-1:0]     load_addr_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic              load_last_i,
    output logic              load_ready_o,
    input  logic              req_valid_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    output logic              req_ready_o,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_instr_o,
    output logic [1:0]        rsp_fault_o,
    output logic              init_done_o
);

    logic [1:0]        state_q, state_d;
    logic [AW-1:0]     init_cnt_q, init_cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_instr_q, rsp_instr_d;
    logic [1:0]        rsp_fault_q, rsp_fault_d;
    logic              init_done_q, init_done_d;

    logic              req_ready_s;
    logic              load_ready_s;
    logic              load_acc_s;
    logic              req_acc_s;
    logic              mem_we_s;
    logic [AW-1:0]     mem_waddr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic [DATA_W-1:0] rd_data_s;
    logic [AW-1:0]     req_word_s;
    logic [1:0]        fault_s;

    imem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (mem_we_s),
        .waddr_i (mem_waddr_s),
        .wdata_i (mem_wdata_s),
        .raddr_i (req_word_s),
        .rdata_o (rd_data_s)
    );

    assign req_word_s = req_addr_i[AW+1:2];

    // Fetch decode; misalignment outranks out-of-range
    always_comb begin
        fault_s = FAULT_OK;
        if (req_addr_i[1:0] != 2'b00) begin
            fault_s = FAULT_MISALIGN;
        end else if (req_addr_i[ADDR_W-1:AW+2] != (ADDR_W-AW-2)'(0)) begin
            fault_s = FAULT_RANGE;
        end else begin
            fault_s = FAULT_OK;
        end
    end

    // Handshake readiness, write-port mux and FSM next state
    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        init_done_d  = init_done_q;
        req_ready_s  = 1'b0;
        load_ready_s = 1'b0;
        mem_we_s     = 1'b0;
        mem_waddr_s  = load_addr_i;
        mem_wdata_s  = load_data_i;
        case (state_q)
            ST_INIT: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = init_cnt_q;
                mem_wdata_s = NOP_WORD;
                init_cnt_d  = init_cnt_q + AW'(1);
                if (init_cnt_q == AW'(DEPTH - 1)) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN: begin
                load_ready_s = !rsp_valid_q;
                // A pending load strobe blocks fetch acceptance this cycle
                req_ready_s  = !load_en_i && (!rsp_valid_q || rsp_ready_i);
                mem_we_s     = load_en_i && load_ready_s;
                if (load_en_i && load_ready_s && !load_last_i) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_LOAD: begin
                load_ready_s = 1'b1;
                mem_we_s     = load_en_i;
                if (load_en_i && load_last_i) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign load_acc_s = load_en_i && load_ready_s;
    assign req_acc_s  = req_valid_i && req_ready_s;

    // Response register: load on accept, clear on consume, otherwise hold
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_instr_d = rsp_instr_q;
        rsp_fault_d = rsp_fault_q;
        if (req_acc_s) begin
            rsp_valid_d = 1'b1;
            rsp_fault_d = fault_s;
            if (fault_s == FAULT_OK) begin
                rsp_instr_d = rd_data_s;
            end else begin
                rsp_instr_d = NOP_WORD;
            end
        end else if (rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= AW'(0);
            rsp_valid_q <= 1'b0;
            rsp_instr_q <= NOP_WORD;
            rsp_fault_q <= FAULT_OK;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_instr_q <= rsp_instr_d;
            rsp_fault_q <= rsp_fault_d;
            init_done_q <= init_done_d;
        end
    end

    assign load_ready_o = load_ready_s;
    assign req_ready_o  = req_ready_s;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_instr_o  = rsp_instr_q;
    assign rsp_fault_o  = rsp_fault_q;
    assign init_done_o  = init_done_q;

    logic unused_s;
    assign unused_s = load_acc_s;

endmodule

// File: tb/tb_imem_loadable.sv
// Directed, table-driven bench for imem_loadable (DEPTH = 64) with hand-written
// sequences for reset fill timing and reset in the middle of a load burst.
module tb_imem_loadable;

    localparam int          DEPTH = 64;
    localparam int          AW    = 6;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic          clk;
    logic          rst_n;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic          load_last;
    logic          load_ready;
    logic          req_valid;
    logic [31:0]   req_addr;
    logic          req_ready;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_instr;
    logic [1:0]    rsp_fault;
    logic          init_done;

    int errors = 0;
    int checks = 0;

    imem_loadable #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(32)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .load_en_i    (load_en),
        .load_addr_i  (load_addr),
        .load_data_i  (load_data),
        .load_last_i  (load_last),
        .load_ready_o (load_ready),
        .req_valid_i  (req_valid),
        .req_addr_i   (req_addr),
        .req_ready_o  (req_ready),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_instr_o  (rsp_instr),
        .rsp_fault_o  (rsp_fault),
        .init_done_o  (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          ld_en;
        logic [AW-1:0] ld_addr;
        logic [31:0]   ld_data;
        logic          ld_last;
        logic          rv;
        logic [31:0]   ra;
        logic          rr;
        logic          e_req_rdy;
        logic          e_ld_rdy;
        logic          e_vld;
        logic [31:0]   e_instr;
        logic [1:0]    e_fault;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic le, input logic [AW-1:0] la, input logic [31:0] ld,
                                input logic ll, input logic rv, input logic [31:0] ra,
                                input logic rr, input logic erq, input logic elr,
                                input logic ev, input logic [31:0] ei, input logic [1:0] ef);
        vec_t v;
        v.ld_en = le; v.ld_addr = la; v.ld_data = ld; v.ld_last = ll;
        v.rv = rv; v.ra = ra; v.rr = rr;
        v.e_req_rdy = erq; v.e_ld_rdy = elr;
        v.e_vld = ev; v.e_instr = ei; v.e_fault = ef;
        return v;
    endfunction

    // Called at a negedge: drive, check readiness, clock once, check response
    task automatic apply(input vec_t v, input string tag);
        load_en   = v.ld_en;
        load_addr = v.ld_addr;
        load_data = v.ld_data;
        load_last = v.ld_last;
        req_valid = v.rv;
        req_addr  = v.ra;
        rsp_ready = v.rr;
        #1;
        chk({tag, "_req_ready"},  {31'd0, req_ready},  {31'd0, v.e_req_rdy});
        chk({tag, "_load_ready"}, {31'd0, load_ready}, {31'd0, v.e_ld_rdy});
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, {31'd0, v.e_vld});
        chk({tag, "_rsp_instr"}, rsp_instr, v.e_instr);
        chk({tag, "_rsp_fault"}, {30'd0, rsp_fault}, {30'd0, v.e_fault});
    endtask

    initial begin
        int cnt;

        //            le    la    ldata         ll    rv    raddr          rr    rqr   ldr   vld   instr          flt
        vecs.push_back(mk(1'b0, 6'd0, 32'h0,        1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b1, NOP,           2'b00));
        vecs.push_back(mk(1'b0, 6'd0, 32'h0,        1'b0, 1'b1, 32'h0000_0004, 1'b1, 1'b1, 1'b0, 1'b1, NOP,           2'b00));
        vecs.push_back(mk(1'b0, 6'd0, 32'h0,        1'b0, 1'b1, 32'h0000_00FC, 1'b1, 1'b1, 1'b0, 1'b1, NOP,           2'b00));
        vecs.push_back(mk(1'b0, 6'd0, 32'h0,        1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, NOP,           2'b00));
        // load burst 0xA, 0xB, 0xC with a stray fetch and an idle cycle inside
        vecs.push_back(mk(1'b1, 6'd0, 32'h0000_000A, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, NOP,           2'b00));
        vecs.push_back(mk(1'b1, 6'd1, 32'h0000_000B, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, NOP,           2'b00));
        vecs.push_back(mk(1'b0, 6'd0, 32'h0,        1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, NOP,           2'b00));
        vecs.push_back(mk(1'b1, 6'd2, 32'h0000_000C, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, NOP,           2'b00));
        vecs.push_back(mk(1'b0, 6'd0, 32'h0,        1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_000A, 2'b00));
        vecs.push_back(mk(1'b0, 6'd0, 32'h0,        1'b0, 1'b1, 32'h0000_0004, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_000B, 2'b00));
        vecs.push_back(mk(1'b0, 6'd0, 32'h0,        1'b0, 1'b1, 32'h0000_0008, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_000C, 2'b00));
        // faults
        vecs.push_back(mk(1'b0, 6'd0, 32'h0,        1'b0, 1'b1, 32'h0000_0006, 1'b1, 1'b1, 1'b0, 1'b1, NOP,           2'b01));
        vecs.push_back(mk(1'b0, 6'd0, 32'h0,        1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b1, 1'b0, 1'b1, NOP,           2'b10));
        vecs.push_back(mk(1'b0, 6'd0, 32'h0,        1'b0, 1'b1, 32'h0000_0102, 1'b1, 1'b1, 1'b0, 1'b1, NOP,           2'b01));
        // back-pressure: response 0xB held three cycles, blocked load not written
        vecs.push_back(mk(1'b0, 6'd0, 32'h0,        1'b0, 1'b1, 32'h0000_0004, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_000B, 2'b00));
        vecs.push_back(mk(1'b0, 6'd0, 32'h0,        1'b0, 1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_000B, 2'b00));
        vecs.push_back(mk(1'b1, 6'd5, 32'h0000_DEAD, 1'b1, 1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_000B, 2'b00));
        vecs.push_back(mk(1'b0, 6'd0, 32'h0,        1'b0, 1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_000B, 2'b00));
        vecs.push_back(mk(1'b0, 6'd0, 32'h0,        1'b0, 1'b1, 32'h0000_0008, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_000C, 2'b00));
        vecs.push_back(mk(1'b0, 6'd0, 32'h0,        1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_000C, 2'b00));
        // load and fetch together: load wins, fetch next cycle sees new word
        vecs.push_back(mk(1'b1, 6'd3, 32'h0000_1234, 1'b1, 1'b1, 32'h0000_000C, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_000C, 2'b00));
        vecs.push_back(mk(1'b0, 6'd0, 32'h0,        1'b0, 1'b1, 32'h0000_000C, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_1234, 2'b00));
        vecs.push_back(mk(1'b0, 6'd0, 32'h0,        1'b0, 1'b1, 32'h0000_0014, 1'b1, 1'b1, 1'b0, 1'b1, NOP,           2'b00));
        vecs.push_back(mk(1'b0, 6'd0, 32'h0,        1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 1'b1, NOP,           2'b10));
        vecs.push_back(mk(1'b0, 6'd0, 32'h0,        1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1, NOP,           2'b01));
        vecs.push_back(mk(1'b0, 6'd0, 32'h0,        1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, NOP,           2'b01));

        rst_n = 1'b0; load_en = 1'b0; load_addr = 6'd0; load_data = 32'h0;
        load_last = 1'b0; req_valid = 1'b0; req_addr = 32'h0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rsp_valid",  {31'd0, rsp_valid},  32'd0);
        chk("rst_rsp_instr",  rsp_instr,           NOP);
        chk("rst_rsp_fault",  {30'd0, rsp_fault},  32'd0);
        chk("rst_init_done",  {31'd0, init_done},  32'd0);
        chk("rst_req_ready",  {31'd0, req_ready},  32'd0);
        chk("rst_load_ready", {31'd0, load_ready}, 32'd0);

        rst_n = 1'b1;
        repeat (DEPTH - 1) @(posedge clk);
        @(negedge clk);
        chk("fill_last_init_done", {31'd0, init_done}, 32'd0);
        chk("fill_last_req_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("fill_end_init_done", {31'd0, init_done}, 32'd1);
        chk("fill_end_req_ready", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("v%0d", i));
        end

        // Reset arriving two words into a four-word burst
        load_en = 1'b1; load_addr = 6'd0; load_data = 32'h0000_0011; load_last = 1'b0;
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        load_addr = 6'd1; load_data = 32'h0000_0022;
        @(negedge clk);
        chk("midload_load_ready", {31'd0, load_ready}, 32'd1);
        chk("midload_req_ready",  {31'd0, req_ready},  32'd0);
        load_addr = 6'd2; load_data = 32'h0000_0033;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_init_done",  {31'd0, init_done},  32'd0);
        chk("midrst_load_ready", {31'd0, load_ready}, 32'd0);
        chk("midrst_rsp_valid",  {31'd0, rsp_valid},  32'd0);
        load_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        do begin
            @(posedge clk);
            cnt++;
            #1;
        end while (!init_done && cnt < 200);
        chk("refill_cycles", cnt, DEPTH);
        @(negedge clk);
        apply(mk(1'b0, 6'd0, 32'h0, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b1, NOP, 2'b00), "refill_w0");
        apply(mk(1'b0, 6'd0, 32'h0, 1'b0, 1'b1, 32'h0000_0004, 1'b1, 1'b1, 1'b0, 1'b1, NOP, 2'b00), "refill_w1");
        apply(mk(1'b0, 6'd0, 32'h0, 1'b0, 1'b1, 32'h0000_0008, 1'b1, 1'b1, 1'b0, 1'b1, NOP, 2'b00), "refill_w2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_loadable.md
# imem_loadable

Parametrised, loadable instruction memory with a valid/ready fetch port. On reset it autonomously fills every word with a NOP, then serves one fetch per cycle with a registered response and per-request fault reporting. A load port lets a boot loader or testbench stream a program in word by word at run time. It sits between the PC/fetch stage and the decode stage of the core.

## Interface
- `DEPTH`, 64: number of words; power of two, at least 4; `AW = $clog2(DEPTH)`.
- `DATA_W`, 32: instruction width.
- `ADDR_W`, 32: byte-address width of `req_addr`.
- `NOP_WORD`, 32'h0000_0013: fill value, also returned on faults.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load_en`  in  1  load-word strobe.
- `load_addr`  in  AW  word index to write.
- `load_data`  in  DATA_W  word to write.
- `load_last`  in  1  marks the final word of a load burst.
- `load_ready`  out  1  a load word is accepted on `load_en && load_ready`.
- `req_valid`  in  1  fetch request.
- `req_addr`  in  ADDR_W  byte address of the fetch.
- `req_ready`  out  1  a request is accepted on `req_valid && req_ready`.
- `rsp_valid`  out  1  response holds valid data.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_instr`  out  DATA_W  fetched word.
- `rsp_fault`  out  2  fault code: 00 = OK, 01 = misaligned, 10 = out of range.
- `init_done`  out  1  high once the fill has completed.

## Operation
- States: INIT, RUN, LOAD.
- Reset values: state = INIT, `init_cnt` = 0, `rsp_valid` = 0, `rsp_instr` = `NOP_WORD`, `rsp_fault` = 00, `init_done` = 0.
- Array contents are not reset directly; INIT overwrites them.
- INIT:
  - Writes `NOP_WORD` to word `init_cnt` every cycle and increments the counter.
  - After writing word DEPTH-1: go to RUN and set `init_done` = 1.
  - `req_ready` = 0 and `load_ready` = 0 throughout.
- RUN:
  - `load_ready` = !`rsp_valid`.
  - `req_ready` = !`load_en` && (!`rsp_valid` || `rsp_ready`).
  - An accepted load writes `mem[load_addr]`. Stay in RUN if `load_last` = 1, otherwise go to LOAD.
  - An accepted load has priority; no fetch is accepted in the same cycle.
- LOAD:
  - `load_ready` = 1 and `req_ready` = 0.
  - Each strobe writes one word.
  - The strobe with `load_last` = 1 writes its word and returns to RUN.
  - Idle cycles with no strobe are allowed.
- Fetch decode:
  - Word index = `req_addr[AW+1:2]`.
  - If `req_addr[1:0]` != 0: fault 01.
  - Else if `req_addr[ADDR_W-1:AW+2]` != 0: fault 10.
  - Misaligned has priority over out of range.
  - On any fault, `rsp_instr` = `NOP_WORD`.
- Response register:
  - Loads on every accepted request.
  - `rsp_valid` clears on `rsp_ready` when no new request is accepted.
  - While `rsp_valid && !rsp_ready`, `rsp_instr` and `rsp_fault` hold stable.

## Timing
- Fill takes exactly DEPTH cycles after reset release; `init_done` and `req_ready` can first be high in the following cycle.
- Fetch latency: request accepted at edge N, response valid after edge N.
- Throughput: one fetch per cycle while `rsp_ready` = 1.
- Write then read: a word written at edge N is returned by a fetch accepted at edge N+1 or later.
- Back-pressure: when `rsp_valid && !rsp_ready`, `req_ready` = 0 and `load_ready` = 0.
- Reset mid-operation: an `rst_n` assertion in any state returns the block to INIT immediately. Any pending response is dropped, and a partial load is discarded because the fill re-runs.
- `load_addr` is an in-range word index by construction; no fault is raised on loads.

## Structure
- Package `imem_pkg` holds:
  - state enum (INIT, RUN, LOAD);
  - fault codes FAULT_OK, FAULT_MISALIGN, FAULT_RANGE;
  - default `NOP_WORD`.
- Sub-module `imem_array`:
  - DEPTH x DATA_W storage;
  - one synchronous write port, muxed between INIT fill and load;
  - one combinational read port.
- The top level holds the FSM, the fill counter, the handshake logic and the response register.

## Test plan
- Reset release, then fetches of 0x0, 0x4 and 0xFC with `rsp_ready` = 1: `req_ready` first high in the cycle after the DEPTH fill cycles; each response is 32'h0000_0013 with fault 00, one cycle after acceptance.
- Load words 0..2 = 0xA, 0xB, 0xC (`load_last` on word 2), then fetch 0x0, 0x4, 0x8 back to back: responses 0xA, 0xB, 0xC on consecutive cycles, all fault 00; `req_ready` = 0 while in LOAD.
- Fetch 0x6, then 0x100, then 0x102 (DEPTH = 64): faults 01, 10, 01 respectively, each with `rsp_instr` = `NOP_WORD`.
- Fetch 0x4 with `rsp_ready` held 0 for 3 cycles: `rsp_instr` and `rsp_fault` stable, `req_ready` = 0 and `load_ready` = 0; with `rsp_ready` = 1 and a new request in the same cycle, the next response appears on the following cycle.
- `rst_n` asserted mid-LOAD after 2 words of a 4-word burst: fill re-runs, and a subsequent fetch of 0x0 returns `NOP_WORD`.
- `load_en` and `req_valid` both high in RUN: the load is written, `req_ready` = 0 that cycle, and the fetch is accepted the next cycle returning the new data.
